icetap_capture_engine: RTL and testbench

ICETAP_CAPTURE_ENGINE -- requirements
Module: icetap_capture_engine

---
 rtl/icetap_capture_engine.sv | 214 +++++++++++++++++++++
 tb/tb_icetap_capture_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icetap_capture_engine.sv
// Logic-analyser style capture engine: pre-trigger ring buffer, masked level/edge
// trigger, optional change-only storage and indexed readback of the finished capture.
module icetap_capture_engine #(
    parameter int NR_SIGNALS = 8,
    parameter int DEPTH_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [NR_SIGNALS-1:0] signals_in,
    input  logic [NR_SIGNALS-1:0] cfg_trig_mask,
    input  logic [NR_SIGNALS-1:0] cfg_trig_value,
    input  logic                  cfg_trig_edge,
    input  logic [DEPTH_BITS-1:0] cfg_pre_samples,
    input  logic                  cfg_store_changes,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  rd_req,
    input  logic [DEPTH_BITS-1:0] rd_addr,
    output logic [NR_SIGNALS-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  armed,
    output logic                  triggered,
    output logic                  done,
    output logic [DEPTH_BITS-1:0] trig_addr
);

    localparam int DEPTH = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS-1:0] ONE = DEPTH_BITS'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [NR_SIGNALS-1:0]   s_q, s_d;
    logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0]   trig_addr_q, trig_addr_d;
    logic [DEPTH_BITS-1:0]   cnt_q, cnt_d;
    logic [NR_SIGNALS-1:0]   mask_q, mask_d;
    logic [NR_SIGNALS-1:0]   value_q, value_d;
    logic                    edge_q, edge_d;
    logic [DEPTH_BITS-1:0]   pre_q, pre_d;
    logic                    changes_q, changes_d;
    logic                    prev_match_q, prev_match_d;
    logic                    first_q, first_d;
    logic [NR_SIGNALS-1:0]   last_q, last_d;
    logic                    triggered_q, triggered_d;
    logic                    armed_q, armed_d;
    logic                    done_q, done_d;
    logic [NR_SIGNALS-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic [NR_SIGNALS-1:0]   mem [DEPTH];
    logic                    mem_we;
    logic                    match;
    logic                    trig_hit;
    logic                    store_ok;
    logic [DEPTH_BITS-1:0]   rd_index;

    assign match    = ((s_q ^ value_q) & mask_q) == '0;
    assign trig_hit = match && (!edge_q || !prev_match_q);
    // In change-only mode a duplicate of the last written sample is dropped.
    assign store_ok = !changes_q || first_q || (s_q != last_q);
    assign rd_index = trig_addr_q - pre_q + rd_addr;

    always_comb begin
        state_d      = state_q;
        s_d          = signals_in;
        wr_ptr_d     = wr_ptr_q;
        trig_addr_d  = trig_addr_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        value_d      = value_q;
        edge_d       = edge_q;
        pre_d        = pre_q;
        changes_d    = changes_q;
        prev_match_d = prev_match_q;
        first_d      = first_q;
        last_d       = last_q;
        triggered_d  = triggered_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        mem_we       = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (state_q == ST_DONE && rd_req) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = mem[rd_index];
                    end
                    if (start) begin
                        mask_d       = cfg_trig_mask;
                        value_d      = cfg_trig_value;
                        edge_d       = cfg_trig_edge;
                        pre_d        = cfg_pre_samples;
                        changes_d    = cfg_store_changes;
                        wr_ptr_d     = '0;
                        cnt_d        = '0;
                        prev_match_d = 1'b0;
                        first_d      = 1'b1;
                        triggered_d  = 1'b0;
                        state_d      = (cfg_pre_samples == '0) ? ST_WAIT_TRIG : ST_PREFILL;
                    end
                end
                ST_PREFILL: begin
                    mem_we = store_ok;
                    if (store_ok) begin
                        cnt_d = cnt_q + ONE;
                        if (cnt_q == pre_q - ONE) begin
                            state_d = ST_WAIT_TRIG;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    prev_match_d = match;
                    if (trig_hit) begin
                        mem_we      = 1'b1;
                        trig_addr_d = wr_ptr_q;
                        triggered_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = (pre_q == '1) ? ST_DONE : ST_POST;
                    end else begin
                        mem_we = store_ok;
                    end
                end
                ST_POST: begin
                    mem_we = store_ok;
                    if (store_ok) begin
                        cnt_d = cnt_q + ONE;
                        // Post-trigger length is DEPTH-1-pre written samples.
                        if (cnt_q == ('1 - pre_q - ONE)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + ONE;
            last_d   = s_q;
            first_d  = 1'b0;
        end

        armed_d = (state_d == ST_PREFILL) || (state_d == ST_WAIT_TRIG) || (state_d == ST_POST);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            wr_ptr_q     <= '0;
            trig_addr_q  <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            value_q      <= '0;
            edge_q       <= 1'b0;
            pre_q        <= '0;
            changes_q    <= 1'b0;
            prev_match_q <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= '0;
            triggered_q  <= 1'b0;
            armed_q      <= 1'b0;
            done_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            wr_ptr_q     <= wr_ptr_d;
            trig_addr_q  <= trig_addr_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            value_q      <= value_d;
            edge_q       <= edge_d;
            pre_q        <= pre_d;
            changes_q    <= changes_d;
            prev_match_q <= prev_match_d;
            first_q      <= first_d;
            last_q       <= last_d;
            triggered_q  <= triggered_d;
            armed_q      <= armed_d;
            done_q       <= done_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Sample memory is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= s_q;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign armed     = armed_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_icetap_capture_engine.sv
// Self-checking bench for icetap_capture_engine: captures driven from generated
// waveforms, readback compared against a queue of expected samples.
module tb_icetap_capture_engine;

    localparam int NR = 8;
    localparam int DB = 4;

    logic          clk;
    logic          reset_;
    logic [NR-1:0] signals_in;
    logic [NR-1:0] cfg_trig_mask;
    logic [NR-1:0] cfg_trig_value;
    logic          cfg_trig_edge;
    logic [DB-1:0] cfg_pre_samples;
    logic          cfg_store_changes;
    logic          start;
    logic          abort;
    logic          rd_req;
    logic [DB-1:0] rd_addr;
    logic [NR-1:0] rd_data;
    logic          rd_valid;
    logic          armed;
    logic          triggered;
    logic          done;
    logic [DB-1:0] trig_addr;

    int checkCount = 0;
    int errorCount = 0;
    int genMode    = 0;
    int cyc        = 0;
    int trigCyc    = -1;
    logic trigWithDone = 1'b0;
    logic [NR-1:0] expQ [$];

    icetap_capture_engine #(.NR_SIGNALS(NR), .DEPTH_BITS(DB)) dut (
        .clk              (clk),
        .reset_           (reset_),
        .signals_in       (signals_in),
        .cfg_trig_mask    (cfg_trig_mask),
        .cfg_trig_value   (cfg_trig_value),
        .cfg_trig_edge    (cfg_trig_edge),
        .cfg_pre_samples  (cfg_pre_samples),
        .cfg_store_changes(cfg_store_changes),
        .start            (start),
        .abort            (abort),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .armed            (armed),
        .triggered        (triggered),
        .done             (done),
        .trig_addr        (trig_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Waveform sampled by the DUT at edge c after the arming edge (c = 0).
    function automatic logic [NR-1:0] gen(input int mode, input int c);
        case (mode)
            1:       return (c == 10) ? 8'h00 : 8'h01;
            2:       return (c < 50) ? 8'h55 : 8'(8'h55 + c - 49);
            default: return 8'(c);
        endcase
    endfunction

    function automatic logic [NR-1:0] expectedRead(input int testId, input int idx);
        case (testId)
            2:       return gen(1, idx);
            3:       return 8'(8'h55 + idx);
            4:       return 8'(8'h11 + idx);
            default: return 8'(8'h1C + idx);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic advance();
        step();
        cyc++;
        if (triggered && trigCyc < 0) begin
            trigCyc      = cyc;
            trigWithDone = done;
        end
        signals_in = gen(genMode, cyc + 1);
    endtask

    task automatic applyStimulus(input logic [NR-1:0] mask, input logic [NR-1:0] value,
                                 input logic edgeMode, input logic [DB-1:0] pre,
                                 input logic changes, input int mode);
        genMode           = mode;
        cfg_trig_mask     = mask;
        cfg_trig_value    = value;
        cfg_trig_edge     = edgeMode;
        cfg_pre_samples   = pre;
        cfg_store_changes = changes;
        signals_in        = gen(mode, 0);
        start             = 1'b1;
        step();
        start             = 1'b0;
        cyc               = 0;
        trigCyc           = -1;
        trigWithDone      = 1'b0;
        signals_in        = gen(mode, 1);
        // Configuration must be latched at start; scramble it afterwards.
        cfg_trig_mask     = ~mask;
        cfg_trig_value    = ~value;
        cfg_trig_edge     = ~edgeMode;
        cfg_pre_samples   = ~pre;
        cfg_store_changes = ~changes;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) advance();
    endtask

    task automatic runUntilDone(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            advance();
            n++;
        end
        checkOutput("done_reached", done, 1);
    endtask

    task automatic readAll(input int testId);
        for (int i = 0; i < 16; i++) begin
            rd_req  = 1'b1;
            rd_addr = 4'(i);
            expQ.push_back(expectedRead(testId, i));
            step();
            checkOutput($sformatf("t%0d_rd_valid_%0d", testId, i), rd_valid, 1);
            if (expQ.size() > 0) begin
                checkOutput($sformatf("t%0d_rd_data_%0d", testId, i), rd_data, expQ.pop_front());
            end
        end
        rd_req = 1'b0;
        step();
        checkOutput("rd_valid_idle_after_burst", rd_valid, 0);
    endtask

    task automatic levelCounterCapture();
        applyStimulus(8'hFF, 8'h20, 1'b0, 4'd4, 1'b0, 0);
        runUntilDone(200);
        checkOutput("t1_trig_cycle", trigCyc, 33);
        checkOutput("t1_trig_addr", trig_addr, 0);
        checkOutput("t1_armed_off", armed, 0);
        checkOutput("t1_triggered", triggered, 1);
        readAll(1);
    endtask

    initial begin
        reset_            = 1'b0;
        signals_in        = '0;
        cfg_trig_mask     = '0;
        cfg_trig_value    = '0;
        cfg_trig_edge     = 1'b0;
        cfg_pre_samples   = '0;
        cfg_store_changes = 1'b0;
        start             = 1'b0;
        abort             = 1'b0;
        rd_req            = 1'b0;
        rd_addr           = '0;
        #12;
        checkOutput("rst_armed", armed, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_trig_addr", trig_addr, 0);
        @(negedge clk);
        reset_ = 1'b1;

        // Reads outside DONE are ignored.
        rd_req = 1'b1;
        step();
        checkOutput("idle_rd_valid", rd_valid, 0);
        rd_req = 1'b0;

        $display("[TB] level trigger on counter, pre=4");
        levelCounterCapture();

        $display("[TB] edge trigger, input already matching at arm");
        applyStimulus(8'h01, 8'h01, 1'b1, 4'd0, 1'b0, 1);
        runUntilDone(100);
        checkOutput("t2_trig_cycle", trigCyc, 1);
        checkOutput("t2_trig_addr", trig_addr, 0);
        readAll(2);

        $display("[TB] change-only storage");
        applyStimulus(8'hFF, 8'h59, 1'b0, 4'd4, 1'b1, 2);
        runUntilDone(300);
        checkOutput("t3_trig_addr", trig_addr, 4);
        readAll(3);

        $display("[TB] pre = DEPTH-1");
        applyStimulus(8'hFF, 8'h20, 1'b0, 4'd15, 1'b0, 0);
        runUntilDone(200);
        checkOutput("t4_trig_cycle", trigCyc, 33);
        checkOutput("t4_done_on_trigger", trigWithDone, 1);
        checkOutput("t4_trig_addr", trig_addr, 0);
        readAll(4);

        $display("[TB] abort with start during POST");
        applyStimulus(8'hFF, 8'h08, 1'b0, 4'd4, 1'b0, 0);
        runCycles(12);
        checkOutput("t5_in_post_armed", armed, 1);
        checkOutput("t5_in_post_triggered", triggered, 1);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        checkOutput("t5_armed", armed, 0);
        checkOutput("t5_triggered", triggered, 0);
        checkOutput("t5_done", done, 0);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        checkOutput("t5_rd_valid", rd_valid, 0);
        checkOutput("t5_still_idle", armed, 0);

        $display("[TB] asynchronous reset in WAIT_TRIG");
        applyStimulus(8'hFF, 8'h40, 1'b0, 4'd2, 1'b0, 0);
        runCycles(5);
        checkOutput("t6_armed_before", armed, 1);
        checkOutput("t6_trig_addr_before", trig_addr, 8);
        #2;
        reset_ = 1'b0;
        #1;
        checkOutput("t6_armed", armed, 0);
        checkOutput("t6_triggered", triggered, 0);
        checkOutput("t6_done", done, 0);
        checkOutput("t6_trig_addr", trig_addr, 0);
        checkOutput("t6_rd_valid", rd_valid, 0);
        checkOutput("t6_rd_data", rd_data, 0);
        @(negedge clk);
        reset_ = 1'b1;
        levelCounterCapture();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
